syncram_be: RTL and testbench

//  Next-generation data memory for the single-cycle MIPS datapath, replacing the fixed 32-bit syncram.

---
 rtl/syncram_be.sv | 94 +++++++++
 tb/tb_syncram_be.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/syncram_be.sv
// Byte-enabled data memory with a base-address window, illegal-access flags and a
// configurable read latency delivered through a valid/data/error shift pipeline.
module syncram_be #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          RD_LAT    = 1,
  parameter string       MEM_FILE  = ""
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cs_i,
  input  logic                oe_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [31:0]         addr_i,
  input  logic [DATA_W-1:0]   din_i,
  output logic [DATA_W-1:0]   dout_o,
  output logic                rvalid_o,
  output logic                rd_err_o,
  output logic                wr_err_o
);

  localparam int          BYTES      = DATA_W / 8;
  localparam int          LB         = $clog2(BYTES);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [63:0] LIMIT      = 64'(BASE_ADDR) + 64'(DEPTH) * 64'(BYTES);
  localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("syncram_be: RD_LAT=%0d is outside 1..4", RD_LAT);
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("syncram_be: DATA_W=%0d is not a multiple of 8", DATA_W);
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_req;
  logic              rd_req;
  logic              aligned;
  logic              in_window;
  logic              legal;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] rd_data_d;

  logic              vld_q [RD_LAT];
  logic              err_q [RD_LAT];
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic              wr_err_q;

  assign wr_req    = cs_i & we_i;
  assign rd_req    = cs_i & oe_i & ~we_i;
  assign aligned   = (addr_i & ALIGN_MASK) == 32'd0;
  assign in_window = (addr_i >= BASE_ADDR) && ({32'd0, addr_i} < LIMIT);
  assign legal     = aligned & in_window;
  assign idx       = AW'((addr_i - BASE_ADDR) >> LB);
  assign rd_data_d = legal ? mem[idx] : '0;

  // Array writes live in the reset block only so that no write lands while rst_ni is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
      wr_err_q <= 1'b0;
    end else begin
      if (wr_req && legal) begin
        for (int b = 0; b < BYTES; b++) begin
          if (be_i[b]) mem[idx][8*b +: 8] <= din_i[8*b +: 8];
        end
      end
      wr_err_q <= wr_req & ~legal;

      vld_q[0] <= rd_req;
      err_q[0] <= rd_req & ~legal;
      if (rd_req) dat_q[0] <= rd_data_d;
      // Data stages only advance behind a valid entry, so the last stage holds between results.
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign dout_o   = dat_q[RD_LAT-1];
  assign rvalid_o = vld_q[RD_LAT-1];
  assign rd_err_o = err_q[RD_LAT-1];
  assign wr_err_o = wr_err_q;

endmodule

// File: tb/tb_syncram_be.sv
// Drives four syncram_be instances (RD_LAT 1..4) from shared inputs and compares them
// against an issue-history reference model of the memory and its read latency.
module tb_syncram_be;

  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          HSIZE = 4096;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs    = 1'b0;
  logic        oe    = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] din   = 32'h0;

  logic [4:1][31:0] doutP;
  logic [4:1]       rvalidP;
  logic [4:1]       rdErrP;
  logic [4:1]       wrErrP;

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 4; g++) begin : g_dut
    syncram_be #(
      .DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(g), .MEM_FILE("")
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .cs_i(cs), .oe_i(oe), .we_i(we), .be_i(be),
      .addr_i(addr), .din_i(din), .dout_o(doutP[g]), .rvalid_o(rvalidP[g]),
      .rd_err_o(rdErrP[g]), .wr_err_o(wrErrP[g])
    );
  end

  logic [31:0] refMem [DEPTH];
  bit          hv [HSIZE];
  bit          he [HSIZE];
  logic [31:0] hd [HSIZE];
  bit          expV [1:4];
  bit          expE [1:4];
  logic [31:0] expD [1:4];
  bit          expWrErr = 1'b0;
  int          cyc      = 0;
  int          lastRst  = 0;
  int          checks   = 0;
  int          errors   = 0;

  function automatic bit isLegal(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH * 4)) && (a % 4 == 0);
  endfunction

  // Reference: each edge records what a read would return from the current image;
  // a latency-L port shows the entry recorded L-1 edges ago unless a reset came since.
  task automatic modelEdge();
    int idx;
    cyc++;
    hv[cyc] = 1'b0;
    he[cyc] = 1'b0;
    hd[cyc] = 32'h0;
    expWrErr = 1'b0;
    if (!rst_n) begin
      lastRst = cyc;
    end else if (cs && we) begin
      if (isLegal(addr)) begin
        idx = int'((addr - BASE) / 4);
        for (int b = 0; b < 4; b++) begin
          if (be[b]) refMem[idx][8*b +: 8] = din[8*b +: 8];
        end
      end else begin
        expWrErr = 1'b1;
      end
    end else if (cs && oe) begin
      hv[cyc] = 1'b1;
      if (isLegal(addr)) hd[cyc] = refMem[int'((addr - BASE) / 4)];
      else he[cyc] = 1'b1;
    end
    for (int L = 1; L <= 4; L++) begin
      int j;
      j = cyc - L + 1;
      if (!rst_n) begin
        expV[L] = 1'b0; expE[L] = 1'b0; expD[L] = 32'h0;
      end else if (j > lastRst && hv[j]) begin
        expV[L] = 1'b1; expE[L] = he[j]; expD[L] = hd[j];
      end else begin
        expV[L] = 1'b0; expE[L] = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compareAll();
    for (int L = 1; L <= 4; L++) begin
      checkOutput($sformatf("rvalid_L%0d@%0d", L, cyc), 32'(rvalidP[L]), 32'(expV[L]));
      checkOutput($sformatf("rd_err_L%0d@%0d", L, cyc), 32'(rdErrP[L]), 32'(expE[L]));
      checkOutput($sformatf("dout_L%0d@%0d", L, cyc), doutP[L], expD[L]);
      checkOutput($sformatf("wr_err_L%0d@%0d", L, cyc), 32'(wrErrP[L]), 32'(expWrErr));
    end
  endtask

  task automatic clockStep();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input logic c, input logic o, input logic w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d);
    cs = c; oe = o; we = w; be = b; addr = a; din = d;
    clockStep();
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    applyStimulus(1'b1, 1'b0, 1'b1, b, a, d);
  endtask

  task automatic doRead(input logic [31:0] a);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Asynchronous assertion mid-cycle: outputs must drop before any clock edge.
  task automatic assertReset();
    #2 rst_n = 1'b0;
    #1;
    lastRst = cyc;
    expWrErr = 1'b0;
    for (int L = 1; L <= 4; L++) begin
      expV[L] = 1'b0; expE[L] = 1'b0; expD[L] = 32'h0;
    end
    compareAll();
  endtask

  initial begin
    logic [31:0] a;
    int r;
    $display("[TB] syncram_be bench start");
    for (int L = 1; L <= 4; L++) begin
      expV[L] = 1'b0; expE[L] = 1'b0; expD[L] = 32'h0;
    end

    assertReset();
    idle(2);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < DEPTH; i++) begin
      doWrite(BASE + 32'(4 * i), (i == 3) ? 32'hCAFE_F00D : $urandom, 4'hF);
    end

    doRead(BASE + 32'h0C);
    checkOutput("preload_rvalid", 32'(rvalidP[1]), 32'h1);
    checkOutput("preload_dout", doutP[1], 32'hCAFE_F00D);
    idle(4);

    doWrite(BASE + 32'h28, 32'h1122_3344, 4'b1111);
    doWrite(BASE + 32'h28, 32'hAABB_CCDD, 4'b0101);
    doRead(BASE + 32'h28);
    checkOutput("byte_en_dout", doutP[1], 32'h11BB_33DD);
    idle(4);

    doRead(BASE + 32'h00);
    doRead(BASE + 32'h04);
    doRead(BASE + 32'h08);
    checkOutput("stream_first_L3", 32'(rvalidP[3]), 32'h1);
    idle(5);

    doWrite(BASE + 32'h26, 32'hDEAD_BEEF, 4'hF);
    checkOutput("misaligned_wr_err", 32'(wrErrP[1]), 32'h1);
    doRead(32'h0FFF_FFFC);
    checkOutput("below_rd_err", 32'(rdErrP[1]), 32'h1);
    checkOutput("below_dout", doutP[1], 32'h0);
    doRead(BASE + 32'(4 * DEPTH));
    checkOutput("above_rd_err", 32'(rdErrP[1]), 32'h1);
    doRead(BASE + 32'(4 * DEPTH - 4));
    doRead(BASE + 32'h01);
    doWrite(BASE + 32'(4 * DEPTH), 32'h1234_5678, 4'hF);
    doRead(BASE + 32'h28);
    checkOutput("unchanged_after_bad_wr", doutP[1], 32'h11BB_33DD);
    idle(5);

    doWrite(BASE + 32'h40, 32'd5, 4'hF);
    idle(2);
    doRead(BASE + 32'h40);
    doWrite(BASE + 32'h40, 32'd9, 4'hF);
    checkOutput("raw_old_L2", doutP[2], 32'd5);
    doRead(BASE + 32'h40);
    idle(1);
    checkOutput("raw_new_L2", doutP[2], 32'd9);
    idle(3);
    doWrite(BASE + 32'h40, 32'hFFFF_FFFF, 4'h0);
    checkOutput("be_zero_no_err", 32'(wrErrP[1]), 32'h0);
    doRead(BASE + 32'h40);
    idle(4);

    doWrite(BASE + 32'h80, 32'h5A5A_1234, 4'hF);
    doRead(BASE + 32'h80);
    idle(1);
    assertReset();
    doWrite(BASE + 32'h80, 32'hDEAD_BEEF, 4'hF);
    idle(1);
    rst_n = 1'b1;
    idle(6);
    doRead(BASE + 32'h80);
    idle(3);
    checkOutput("after_reset_L4", doutP[4], 32'h5A5A_1234);
    idle(2);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 6) a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (r == 7) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
      else             a = $urandom;
      r = $urandom_range(0, 5);
      case (r)
        0:       applyStimulus(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), a, $urandom);
        1, 2:    applyStimulus(1'b1, 1'b0, 1'b1, 4'($urandom), a, $urandom);
        3, 4:    applyStimulus(1'b1, 1'b1, 1'b0, 4'($urandom), a, $urandom);
        default: applyStimulus(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), a, $urandom);
      endcase
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
